grf_writeback: RTL and testbench

Writeback queue that sits in front of the GRF write port and acts as its sole writer. It accepts register-write requests from the retiring stage via a valid/ready handshake, buffers them in a small in-order FIFO, and drains one per cycle onto the GRF write interface (WE/WA/WD/PC4). It also forwards the youngest pending value for any register still in flight, so readers never see stale GRF contents while a write is queued.

---
 rtl/grf_writeback_if.sv | 33 +++
 rtl/grf_writeback.sv | 110 +++++++++++
 tb/tb_grf_writeback.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/grf_writeback_if.sv
// Handshake, GRF write and forwarding bundle for grf_writeback.
// slave = the writeback queue, master = its surroundings.
interface grf_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wa;
  logic [31:0] in_wd;
  logic [31:0] in_pc;
  logic        drain_hold;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc4;
  logic [4:0]  fwd_ra1;
  logic [4:0]  fwd_ra2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic        empty;

  modport master (
    output in_valid, in_wa, in_wd, in_pc, drain_hold, fwd_ra1, fwd_ra2,
    input  in_ready, grf_we, grf_wa, grf_wd, grf_pc4,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, empty
  );

  modport slave (
    input  in_valid, in_wa, in_wd, in_pc, drain_hold, fwd_ra1, fwd_ra2,
    output in_ready, grf_we, grf_wa, grf_wd, grf_pc4,
           fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, empty
  );
endinterface

// File: rtl/grf_writeback.sv
// In-order writeback FIFO and sole writer of the GRF, with youngest-first forwarding.
// Optional GRF_WB_TRACE_EN prints each issued write on its pop edge.
module grf_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  grf_writeback_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned XW = 5;
  localparam int unsigned DW = 32;

  logic [XW-1:0] r_wa [DEPTH];
  logic [DW-1:0] r_wd [DEPTH];
  logic [DW-1:0] r_pc [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          r_we;
  logic [XW-1:0] r_owa;
  logic [DW-1:0] r_owd;
  logic [DW-1:0] r_opc4;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_idx;
  logic [DW:0]   w_fwd1;
  logic [DW:0]   w_fwd2;

  // Same-cycle pop is deliberately ignored: a full queue refuses input.
  assign w_ready = (r_count < CW'(DEPTH));
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = (r_count != '0) && !bus.drain_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_owa   <= '0;
      r_owd   <= '0;
      r_opc4  <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_we <= w_pop;
      if (w_pop) begin
        r_owa  <= r_wa[r_head];
        r_owd  <= r_wd[r_head];
        r_opc4 <= r_pc[r_head] + DW'(4);
      end
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wa[r_tail] <= bus.in_wa;
      r_wd[r_tail] <= bus.in_wd;
      r_pc[r_tail] <= bus.in_pc;
    end
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && w_pop)
      $display("@%h: $%d <= %h", r_pc[r_head], r_wa[r_head], r_wd[r_head]);
  end
`endif

  // Oldest-to-youngest scan so later matches override earlier ones.
  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    w_idx  = '0;
    if (r_we && (r_owa == bus.fwd_ra1)) w_fwd1 = {1'b1, r_owd};
    if (r_we && (r_owa == bus.fwd_ra2)) w_fwd2 = {1'b1, r_owd};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if (CW'(i) < r_count) begin
        if (r_wa[w_idx] == bus.fwd_ra1) w_fwd1 = {1'b1, r_wd[w_idx]};
        if (r_wa[w_idx] == bus.fwd_ra2) w_fwd2 = {1'b1, r_wd[w_idx]};
      end
    end
    if (bus.fwd_ra1 == '0) w_fwd1 = '0;
    if (bus.fwd_ra2 == '0) w_fwd2 = '0;
  end

  assign bus.in_ready  = w_ready;
  assign bus.grf_we    = r_we;
  assign bus.grf_wa    = r_owa;
  assign bus.grf_wd    = r_owd;
  assign bus.grf_pc4   = r_opc4;
  assign bus.fwd_hit1  = w_fwd1[DW];
  assign bus.fwd_data1 = w_fwd1[DW-1:0];
  assign bus.fwd_hit2  = w_fwd2[DW];
  assign bus.fwd_data2 = w_fwd2[DW-1:0];
  assign bus.empty     = (r_count == '0) && !r_we;
endmodule

// File: tb/tb_grf_writeback.sv
// Directed and random bench for grf_writeback against a queue-based reference model.
module tb_grf_writeback;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  logic clk;
  logic reset;
  grf_writeback_if bus ();

  grf_writeback #(.DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_issued = 0;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_pc4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to ra wins; the issued write is older than anything queued.
  function automatic void mfwd(input logic [4:0] ra, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (ra == 5'd0) return;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wa == ra) begin
        hit = 1'b1;
        d   = q[i].wd;
        return;
      end
    end
    if (m_we && m_wa == ra) begin
      hit = 1'b1;
      d   = m_wd;
    end
  endfunction

  task automatic check_all(input logic [4:0] ra1, input logic [4:0] ra2);
    logic h1, h2;
    logic [31:0] d1, d2;
    mfwd(ra1, h1, d1);
    mfwd(ra2, h2, d2);
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    chk("empty",    32'(bus.empty),    32'(q.size() == 0 && !m_we));
    chk("grf_we",   32'(bus.grf_we),   32'(m_we));
    chk("grf_wa",   32'(bus.grf_wa),   32'(m_wa));
    chk("grf_wd",   bus.grf_wd,        m_wd);
    chk("grf_pc4",  bus.grf_pc4,       m_pc4);
    chk("fwd_hit1", 32'(bus.fwd_hit1), 32'(h1));
    chk("fwd_data1", bus.fwd_data1,    d1);
    chk("fwd_hit2", 32'(bus.fwd_hit2), 32'(h2));
    chk("fwd_data2", bus.fwd_data2,    d2);
    if (bus.grf_we) n_issued++;
  endtask

  // One clock: drive just after an edge, check at the falling edge, advance model at the next edge.
  task automatic cyc(input logic v, input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pc,
                     input logic hold, input logic [4:0] ra1, input logic [4:0] ra2);
    bit acc;
    bus.in_valid   = v;
    bus.in_wa      = wa;
    bus.in_wd      = wd;
    bus.in_pc      = pc;
    bus.drain_hold = hold;
    bus.fwd_ra1    = ra1;
    bus.fwd_ra2    = ra2;
    @(negedge clk);
    check_all(ra1, ra2);
    @(posedge clk);
    acc = v && (q.size() < DEPTH);
    if (q.size() != 0 && !hold) begin
      m_we  = 1'b1;
      m_wa  = q[0].wa;
      m_wd  = q[0].wd;
      m_pc4 = q[0].pc + 32'd4;
      void'(q.pop_front());
    end else begin
      m_we = 1'b0;
    end
    if (acc) q.push_back('{wa: wa, wd: wd, pc: pc});
    #1;
  endtask

  task automatic idle(input logic hold);
    cyc(1'b0, 5'd0, 32'd0, 32'd0, hold, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.drain_hold = 1'b0;
    @(posedge clk);
    q.delete();
    m_we  = 1'b0;
    m_wa  = '0;
    m_wd  = '0;
    m_pc4 = '0;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_wa = '0; bus.in_wd = '0; bus.in_pc = '0;
    bus.drain_hold = 1'b0; bus.fwd_ra1 = '0; bus.fwd_ra2 = '0;
    do_reset();
    chk("rst_we",    32'(bus.grf_we),   32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_empty", 32'(bus.empty),    32'd1);
    chk("rst_pc4",   bus.grf_pc4,       32'd0);

    // single write
    cyc(1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd5, 5'd0);
    idle(1'b0);
    chk("single_we",  32'(bus.grf_we), 32'd1);
    chk("single_wa",  32'(bus.grf_wa), 32'd5);
    chk("single_wd",  bus.grf_wd,      32'h1234);
    chk("single_pc4", bus.grf_pc4,     32'h3004);
    idle(1'b0);
    chk("single_we_off", 32'(bus.grf_we), 32'd0);
    chk("single_empty",  32'(bus.empty),  32'd1);

    // fill with hold, refuse 5th, then drain in order
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'(10 + i), 32'(100 + i), 32'h4000 + 32'(4 * i), 1'b1, 5'd11, 5'd13);
    chk("fill_ready", 32'(bus.in_ready), 32'd0);
    cyc(1'b1, 5'd20, 32'hdead, 32'h4100, 1'b1, 5'd20, 5'd10);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("drain_wa", 32'(bus.grf_wa), 32'(10 + i));
      chk("drain_wd", bus.grf_wd,      32'(100 + i));
      if (i == 0) chk("drain_ready", 32'(bus.in_ready), 32'd1);
    end
    idle(1'b0);
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // forwarding priority and $0
    cyc(1'b1, 5'd8, 32'hA, 32'h5000, 1'b1, 5'd8, 5'd0);
    cyc(1'b1, 5'd8, 32'hB, 32'h5004, 1'b1, 5'd8, 5'd0);
    cyc(1'b1, 5'd0, 32'h77, 32'h5008, 1'b1, 5'd8, 5'd0);
    #1;
    chk("fwd_hit1",  32'(bus.fwd_hit1), 32'd1);
    chk("fwd_data1", bus.fwd_data1,     32'hB);
    chk("fwd_hit2",  32'(bus.fwd_hit2), 32'd0);
    chk("fwd_data2", bus.fwd_data2,     32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd8, 5'd0);

    // wrap-around: 10 pushes, hold every third cycle
    n_issued = 0;
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 5'(i + 1), 32'h500 + 32'(i), 32'h6000 + 32'(4 * i), (i % 3) == 0, 5'(i), 5'(i + 1));
    for (int i = 0; i < 8; i++) idle(1'b0);
    chk("wrap_issued", 32'(n_issued), 32'd10);
    chk("wrap_empty",  32'(bus.empty), 32'd1);

    // reset mid-drain
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'(3 + i), 32'h900 + 32'(i), 32'h7000, 1'b1, 5'd3, 5'd4);
    idle(1'b0);
    chk("midrst_we_pre", 32'(bus.grf_we), 32'd1);
    do_reset();
    chk("midrst_we",    32'(bus.grf_we),   32'd0);
    chk("midrst_empty", 32'(bus.empty),    32'd1);
    chk("midrst_ready", 32'(bus.in_ready), 32'd1);
    n_issued = 0;
    for (int i = 0; i < 4; i++) idle(1'b0);
    chk("midrst_no_writes", 32'(n_issued), 32'd0);

    // simultaneous push and pop at count 2
    cyc(1'b1, 5'd21, 32'h21, 32'h8000, 1'b1, 5'd21, 5'd22);
    cyc(1'b1, 5'd22, 32'h22, 32'h8004, 1'b1, 5'd21, 5'd22);
    cyc(1'b1, 5'd23, 32'h23, 32'h8008, 1'b0, 5'd21, 5'd23);
    chk("pp_wa", 32'(bus.grf_wa), 32'd21);
    cyc(1'b1, 5'd24, 32'h24, 32'h800c, 1'b1, 5'd22, 5'd24);
    cyc(1'b1, 5'd25, 32'h25, 32'h8010, 1'b1, 5'd22, 5'd24);
    chk("pp_full", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 6; i++) idle(1'b0);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cyc(($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
          ($urandom % 3) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) idle(1'b0);
    chk("final_empty", 32'(bus.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
